// File: rtl/branch_predictor_if.sv
// Fetch/resolve signal bundle between the pipeline (master) and the branch predictor (slave).
interface branch_predictor_if #(
  parameter int idx_width = 4
);
  logic [31:0]          fetch_pc;
  logic                 pred_taken;
  logic [31:0]          pred_target;
  logic [idx_width-1:0] btb_idx_out;
  logic [idx_width-1:0] bht_idx_out;

  logic                 upd_valid;
  logic                 upd_is_branch;
  logic [31:0]          upd_pc;
  logic [idx_width-1:0] upd_btb_idx;
  logic [idx_width-1:0] upd_bht_idx;
  logic                 upd_pred_taken;
  logic [31:0]          upd_pred_addr;
  logic                 upd_taken;
  logic [31:0]          upd_target;
  logic                 mispredict;
  logic [31:0]          redirect_pc;

  modport master (
    output fetch_pc, upd_valid, upd_is_branch, upd_pc, upd_btb_idx, upd_bht_idx,
           upd_pred_taken, upd_pred_addr, upd_taken, upd_target,
    input  pred_taken, pred_target, btb_idx_out, bht_idx_out, mispredict, redirect_pc
  );

  modport slave (
    input  fetch_pc, upd_valid, upd_is_branch, upd_pc, upd_btb_idx, upd_bht_idx,
           upd_pred_taken, upd_pred_addr, upd_taken, upd_target,
    output pred_taken, pred_target, btb_idx_out, bht_idx_out, mispredict, redirect_pc
  );
endinterface

// File: rtl/branch_predictor.sv
// BTB + 2-bit-counter BHT branch predictor with same-cycle lookup and resolve-time training.
// Optional feature: define BP_GSHARE_EN to XOR a non-speculative global history into the BHT index.
module branch_predictor #(
  parameter int idx_width = 4
) (
  input logic              clk,
  input logic              rst,
  branch_predictor_if.slave bp
);
  localparam int entries   = 1 << idx_width;
  localparam int tag_width = 30 - idx_width;

  typedef struct packed {
    logic [tag_width-1:0] tag;
    logic [31:0]          target;
  } btb_entry_t;

  logic [entries-1:0]   btb_valid;
  btb_entry_t           btb_mem [entries];
  logic [1:0]           bht     [entries];

  logic [idx_width-1:0] btb_idx;
  logic [idx_width-1:0] bht_idx;
  logic [tag_width-1:0] fetch_tag;
  logic                 hit;

  assign btb_idx   = bp.fetch_pc[idx_width+1:2];
  assign fetch_tag = bp.fetch_pc[31:idx_width+2];

`ifdef BP_GSHARE_EN
  logic [idx_width-1:0] ghr;

  // Only resolved conditional branches shift history, so it never needs repair.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr <= '0;
    end else if (bp.upd_valid && bp.upd_is_branch) begin
      ghr <= {ghr[idx_width-2:0], bp.upd_taken};
    end
  end

  assign bht_idx = btb_idx ^ ghr;
`else
  assign bht_idx = btb_idx;
`endif

  function automatic logic [1:0] ctr_next(logic [1:0] ctr, logic is_branch, logic taken);
    if (!is_branch) return 2'b11;
    if (taken)      return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid <= '0;
      for (int i = 0; i < entries; i++) bht[i] <= 2'b01;
    end else if (bp.upd_valid) begin
      bht[bp.upd_bht_idx] <= ctr_next(bht[bp.upd_bht_idx], bp.upd_is_branch, bp.upd_taken);
      if (bp.upd_taken) btb_valid[bp.upd_btb_idx] <= 1'b1;
    end
  end

  // NOTE: the BTB payload array has no reset; the valid bits make stale contents harmless.
  always_ff @(posedge clk) begin
    if (!rst && bp.upd_valid && bp.upd_taken) begin
      btb_mem[bp.upd_btb_idx] <= '{tag: bp.upd_pc[31:idx_width+2], target: bp.upd_target};
    end
  end

  // Lookup reads the arrays directly, so a same-cycle update is not visible until next cycle.
  assign hit            = btb_valid[btb_idx] && (btb_mem[btb_idx].tag == fetch_tag);
  assign bp.pred_taken  = hit && bht[bht_idx][1];
  assign bp.pred_target = bp.pred_taken ? btb_mem[btb_idx].target : bp.fetch_pc + 32'd4;
  assign bp.btb_idx_out = btb_idx;
  assign bp.bht_idx_out = bht_idx;

  // NOTE: every output is a continuous assign of a complete expression, so no latch can form.
  assign bp.mispredict  = !rst && bp.upd_valid &&
                          ((bp.upd_taken != bp.upd_pred_taken) ||
                           (bp.upd_taken && (bp.upd_target != bp.upd_pred_addr)));
  assign bp.redirect_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + 32'd4;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios then random traffic against a table model.
module tb_branch_predictor;
  localparam int IDX = 4;
  localparam int N   = 1 << IDX;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_if #(.idx_width(IDX)) bp ();
  branch_predictor #(.idx_width(IDX)) dut (.clk(clk), .rst(rst), .bp(bp.slave));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference tables, expressed with plain integers.
  bit          m_valid  [N];
  int unsigned m_tag    [N];
  int unsigned m_target [N];
  int          m_ctr    [N];
  int unsigned m_ghr;

  int unsigned pool [8] = '{32'h100, 32'h140, 32'h0C, 32'h1000,
                            32'h2004, 32'h3008, 32'h44, 32'hFFFF_FFFC};

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned btb_index(int unsigned pc);
    return (pc >> 2) % N;
  endfunction

  function automatic int unsigned bht_index(int unsigned pc);
`ifdef BP_GSHARE_EN
    return ((pc >> 2) % N) ^ m_ghr;
`else
    return (pc >> 2) % N;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_ghr = 0;
  endtask

  task automatic model_check();
    int unsigned pc, bi, hi, exp_tgt;
    bit          exp_tk, exp_mp;
    pc      = bp.fetch_pc;
    bi      = btb_index(pc);
    hi      = bht_index(pc);
    exp_tk  = m_valid[bi] && (m_tag[bi] == (pc >> (IDX + 2))) && (m_ctr[hi] >= 2);
    exp_tgt = exp_tk ? m_target[bi] : pc + 32'd4;
    check("pred_taken",  bp.pred_taken,  exp_tk);
    check("pred_target", bp.pred_target, exp_tgt);
    check("btb_idx_out", bp.btb_idx_out, bi);
    check("bht_idx_out", bp.bht_idx_out, hi);
    exp_mp = !rst && bp.upd_valid &&
             ((bp.upd_taken != bp.upd_pred_taken) ||
              (bp.upd_taken && bp.upd_target != bp.upd_pred_addr));
    check("mispredict", bp.mispredict, exp_mp);
    if (!rst && bp.upd_valid)
      check("redirect_pc", bp.redirect_pc,
            bp.upd_taken ? bp.upd_target : bp.upd_pc + 32'd4);
  endtask

  // Apply this cycle's update to the model, then advance to the next drive point.
  task automatic commit();
    int unsigned bi, hi;
    if (rst) begin
      model_reset();
    end else if (bp.upd_valid) begin
      hi = bp.upd_bht_idx;
      bi = bp.upd_btb_idx;
      if (bp.upd_is_branch) begin
        m_ctr[hi] = bp.upd_taken ? ((m_ctr[hi] < 3) ? m_ctr[hi] + 1 : 3)
                                 : ((m_ctr[hi] > 0) ? m_ctr[hi] - 1 : 0);
        m_ghr = ((m_ghr << 1) | bp.upd_taken) % N;
      end else begin
        m_ctr[hi] = 3;
      end
      if (bp.upd_taken) begin
        m_valid[bi]  = 1'b1;
        m_tag[bi]    = bp.upd_pc >> (IDX + 2);
        m_target[bi] = bp.upd_target;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_upd(bit is_branch, int unsigned pc, bit taken, int unsigned target,
                         bit pred_tk, int unsigned pred_addr, int unsigned bht_i);
    bp.upd_valid      = 1'b1;
    bp.upd_is_branch  = is_branch;
    bp.upd_pc         = pc;
    bp.upd_btb_idx    = IDX'(btb_index(pc));
    bp.upd_bht_idx    = IDX'(bht_i);
    bp.upd_taken      = taken;
    bp.upd_target     = target;
    bp.upd_pred_taken = pred_tk;
    bp.upd_pred_addr  = pred_addr;
  endtask

  task automatic idle();
    bp.upd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bp.fetch_pc = 32'h100;
    set_upd(1'b1, 32'h500, 1'b1, 32'h600, 1'b0, 32'h0, 0);
    idle();
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Reset state lookup.
    bp.fetch_pc = 32'h100;
    #1;
    check("rst_pred_taken", bp.pred_taken, 1'b0);
    check("rst_pred_target", bp.pred_target, 32'h104);
    check("rst_btb_idx", bp.btb_idx_out, 0);
    check("rst_bht_idx", bp.bht_idx_out, 0);
    check("idle_mispredict", bp.mispredict, 1'b0);
    model_check();
    commit();

    // Two taken updates 0x100 -> 0x200, carried prediction not-taken.
    for (int k = 0; k < 2; k++) begin
      set_upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 0);
      #1;
      check("train_mispredict", bp.mispredict, 1'b1);
      check("train_redirect", bp.redirect_pc, 32'h200);
      model_check();
      commit();
    end
    idle();
    #1;
`ifndef BP_GSHARE_EN
    check("trained_taken", bp.pred_taken, 1'b1);
    check("trained_target", bp.pred_target, 32'h200);
`endif
    model_check();
    commit();

    // Saturate high, then drive down to 00 with correctly predicted not-taken outcomes.
    set_upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 0);
    #1;
    check("correct_taken_mp", bp.mispredict, 1'b0);
    model_check();
    commit();
    for (int k = 0; k < 4; k++) begin
      set_upd(1'b1, 32'h100, 1'b0, 32'h200, 1'b0, 32'h104, 0);
      #1;
      check("correct_nt_mp", bp.mispredict, 1'b0);
      check("nt_redirect", bp.redirect_pc, 32'h104);
      model_check();
      commit();
    end
    idle();
    #1;
    check("sat_low_taken", bp.pred_taken, 1'b0);
    model_check();
    commit();

    // Aliasing: jump at 0x140 shares index 0 with a different tag.
    set_upd(1'b0, 32'h140, 1'b1, 32'h900, 1'b0, 32'h144, 0);
    #1; model_check(); commit();
    idle();
    #1;
    check("alias_taken", bp.pred_taken, 1'b0);
    check("alias_target", bp.pred_target, 32'h104);
    model_check();
    commit();

    // Same-cycle lookup and update of index 3: no bypass.
    bp.fetch_pc = 32'h0C;
    set_upd(1'b1, 32'h0C, 1'b1, 32'h80, 1'b0, 32'h10, 3);
    #1;
    check("same_cycle_taken", bp.pred_taken, 1'b0);
    model_check();
    commit();
    idle();
    #1;
`ifndef BP_GSHARE_EN
    check("next_cycle_taken", bp.pred_taken, 1'b1);
    check("next_cycle_target", bp.pred_target, 32'h80);
`endif
    model_check();
    commit();

    // Reset with a pending update: update dropped, mispredict held low.
    rst = 1'b1;
    set_upd(1'b1, 32'h0C, 1'b1, 32'h70, 1'b0, 32'h10, 3);
    #1;
    check("rst_mispredict", bp.mispredict, 1'b0);
    model_check();
    commit();
    rst = 1'b0;
    idle();
    bp.fetch_pc = 32'h0C;
    #1;
    check("post_rst_taken", bp.pred_taken, 1'b0);
    check("post_rst_target", bp.pred_target, 32'h10);
    model_check();
    commit();

    // History: two taken branch outcomes, then look up 0x10.
    for (int k = 0; k < 2; k++) begin
      set_upd(1'b1, 32'h300, 1'b1, 32'h400, 1'b0, 32'h304, 0);
      #1; model_check(); commit();
    end
    idle();
    bp.fetch_pc = 32'h10;
    #1;
`ifdef BP_GSHARE_EN
    check("gshare_bht_idx", bp.bht_idx_out, 4'h7);
`else
    check("plain_bht_idx", bp.bht_idx_out, 4'h4);
`endif
    model_check();
    commit();

    // PC+4 wraps at the top of the address space.
    bp.fetch_pc = 32'hFFFF_FFFC;
    #1;
    check("wrap_target", bp.pred_target, 32'h0);
    model_check();
    commit();

    // Random traffic over a small PC pool so entries hit, alias and retrain.
    for (int c = 0; c < 400; c++) begin
      int unsigned upc;
      bit          br, tk;
      rst = ($urandom_range(0, 63) == 0);
      bp.fetch_pc = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) != 0) begin
        upc = pool[$urandom_range(0, 7)];
        br  = ($urandom_range(0, 3) != 0);
        tk  = br ? 1'($urandom_range(0, 1)) : 1'b1;
        set_upd(br, upc, tk, {$urandom_range(0, 255), 2'b00},
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) != 0) ? upc + 32'd4 : {$urandom_range(0, 255), 2'b00},
                $urandom_range(0, N - 1));
      end else begin
        idle();
      end
      #1;
      model_check();
      commit();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
